// File: rtl/axi_wr_gpio_bridge_if.sv
// AXI4 write-channel bundle (AW, W, B) used between the LSU AXI master and
// the GPIO bridge. Data path is fixed at 64 bits with 8 byte strobes.
//   master: drives aw*/w* and bready, observes awready/wready/b*
//   slave : the reverse
interface axi_wr_gpio_bridge_if #(
  parameter int unsigned ID_W = 3
);
  logic            s_awvalid;
  logic            s_awready;
  logic [ID_W-1:0] s_awid;
  logic [31:0]     s_awaddr;
  logic [7:0]      s_awlen;
  logic [1:0]      s_awburst;
  logic            s_wvalid;
  logic            s_wready;
  logic [63:0]     s_wdata;
  logic [7:0]      s_wstrb;
  logic            s_wlast;
  logic            s_bvalid;
  logic            s_bready;
  logic [ID_W-1:0] s_bid;
  logic [1:0]      s_bresp;

  modport master (
    output s_awvalid, s_awid, s_awaddr, s_awlen, s_awburst,
    output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bid, s_bresp
  );

  modport slave (
    input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awburst,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    output s_awready, s_wready, s_bvalid, s_bid, s_bresp
  );
endinterface

// File: rtl/axi_wr_gpio_bridge.sv
// AXI4 write-only slave driving user-area pads and logic-analyzer lines.
// NUM_CH 32-bit channel registers plus one output-enable register, byte-strobe
// merge, INCR/FIXED bursts, OKAY/SLVERR response, one outstanding transaction.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   axi                : AXI write channels (slave side)
//   gpio_out_o         : ch_reg[0][OUT_W-1:0]
//   gpio_oeb_o         : active-low pad enables (~oe_reg)
//   la_data_o          : all channel registers concatenated, ch0 in the LSBs
//   wr_pulse_o         : one-cycle pulse per channel written on a beat
module axi_wr_gpio_bridge #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned OUT_W     = 28,
  parameter logic [31:0] BASE_ADDR = 32'hD000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  axi_wr_gpio_bridge_if.slave   axi,
  output logic [OUT_W-1:0]      gpio_out_o,
  output logic [OUT_W-1:0]      gpio_oeb_o,
  output logic [32*NUM_CH-1:0]  la_data_o,
  output logic [NUM_CH-1:0]     wr_pulse_o
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  localparam logic [28:0] BASE_DW  = BASE_ADDR[31:3];
  localparam logic [29:0] NUM_REGS = 30'(NUM_CH + 1);
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  BURST_WRAP = 2'b10;

  state_t            state;
  logic [ID_W-1:0]   id;
  logic [28:0]       addr_dw;   // beat address in 8-byte units
  logic [7:0]        len;
  logic [7:0]        beat_cnt;
  logic [1:0]        burst;
  logic              err;
  logic [31:0]       ch_reg [NUM_CH];
  logic [OUT_W-1:0]  oe_reg;
  logic [NUM_CH-1:0] wr_pulse;
  logic              awready, wready, bvalid;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  logic [28:0] off_dw;
  logic [29:0] lo_idx, hi_idx;
  logic        lo_ok, hi_ok, lo_wr, hi_wr, last_cnt, beat_err, w_hs;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] data,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  // Register index = word offset; the low lane is always even, the high lane odd,
  // so both lanes of one beat never target the same register.
  always_comb begin
    off_dw   = addr_dw - BASE_DW;
    lo_idx   = {off_dw, 1'b0};
    hi_idx   = {off_dw, 1'b1};
    lo_ok    = lo_idx < NUM_REGS;
    hi_ok    = hi_idx < NUM_REGS;
    lo_wr    = !err && lo_ok && (|axi.s_wstrb[3:0]);
    hi_wr    = !err && hi_ok && (|axi.s_wstrb[7:4]);
    last_cnt = (beat_cnt == len);
    w_hs     = wready && axi.s_wvalid;
    beat_err = (!err && ((!lo_ok && (|axi.s_wstrb[3:0])) ||
                         (!hi_ok && (|axi.s_wstrb[7:4])))) ||
               (last_cnt != axi.s_wlast);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      id       <= '0;
      addr_dw  <= '0;
      len      <= '0;
      beat_cnt <= '0;
      burst    <= '0;
      err      <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) ch_reg[i] <= '0;
      oe_reg   <= '0;
      wr_pulse <= '0;
      awready  <= 1'b1;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      bid      <= '0;
    end else begin
      wr_pulse <= '0;
      case (state)
        IDLE: begin
          if (axi.s_awvalid) begin
            id       <= axi.s_awid;
            addr_dw  <= axi.s_awaddr[31:3];
            len      <= axi.s_awlen;
            burst    <= axi.s_awburst;
            beat_cnt <= '0;
            err      <= (axi.s_awburst == BURST_WRAP);
            awready  <= 1'b0;
            wready   <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (lo_wr && lo_idx == 30'(i)) begin
                ch_reg[i]   <= merge(ch_reg[i], axi.s_wdata[31:0], axi.s_wstrb[3:0]);
                wr_pulse[i] <= 1'b1;
              end
              if (hi_wr && hi_idx == 30'(i)) begin
                ch_reg[i]   <= merge(ch_reg[i], axi.s_wdata[63:32], axi.s_wstrb[7:4]);
                wr_pulse[i] <= 1'b1;
              end
            end
            if (lo_wr && lo_idx == 30'(NUM_CH))
              oe_reg <= OUT_W'(merge(32'(oe_reg), axi.s_wdata[31:0], axi.s_wstrb[3:0]));
            if (hi_wr && hi_idx == 30'(NUM_CH))
              oe_reg <= OUT_W'(merge(32'(oe_reg), axi.s_wdata[63:32], axi.s_wstrb[7:4]));
            beat_cnt <= beat_cnt + 8'd1;
            if (burst == BURST_INCR) addr_dw <= addr_dw + 29'd1;
            err <= err || beat_err;
            if (last_cnt || axi.s_wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (err || beat_err) ? 2'b10 : 2'b00;
              bid    <= id;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (axi.s_bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.s_awready = awready;
  assign axi.s_wready  = wready;
  assign axi.s_bvalid  = bvalid;
  assign axi.s_bresp   = bresp;
  assign axi.s_bid     = bid;
  assign gpio_out_o    = ch_reg[0][OUT_W-1:0];
  assign gpio_oeb_o    = ~oe_reg;
  assign wr_pulse_o    = wr_pulse;

  always_comb begin
    la_data_o = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) la_data_o[32*i +: 32] = ch_reg[i];
  end

endmodule

// File: tb/tb_axi_wr_gpio_bridge.sv
module tb_axi_wr_gpio_bridge;
  localparam logic [31:0] BASE = 32'hD000_0000;
  localparam int LIMIT = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_wr_gpio_bridge_if #(.ID_W(3)) bus();
  logic [27:0]  gpio_out, gpio_oeb;
  logic [127:0] la;
  logic [3:0]   pulse;

  axi_wr_gpio_bridge #(
    .DATA_W(64), .ID_W(3), .NUM_CH(4), .OUT_W(28), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .axi(bus.slave),
    .gpio_out_o(gpio_out), .gpio_oeb_o(gpio_oeb), .la_data_o(la), .wr_pulse_o(pulse)
  );

  int checks = 0;
  int errors = 0;

  // All stimulus helpers are entered and left on a falling edge.
  task automatic aw_send(input logic [2:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    bus.s_awvalid = 1'b1; bus.s_awid = id; bus.s_awaddr = addr;
    bus.s_awlen = len; bus.s_awburst = burst;
    while (!bus.s_awready && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n >= LIMIT) begin errors++; $display("FAIL aw_timeout: awready=%b required 1", bus.s_awready); end
    @(posedge clk); @(negedge clk);
    bus.s_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    bus.s_wvalid = 1'b1; bus.s_wdata = data; bus.s_wstrb = strb; bus.s_wlast = last;
    while (!bus.s_wready && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n >= LIMIT) begin errors++; $display("FAIL w_timeout: wready=%b required 1", bus.s_wready); end
    @(posedge clk); @(negedge clk);
    bus.s_wvalid = 1'b0;
  endtask

  task automatic b_ack();
    int n = 0;
    bus.s_bready = 1'b1;
    while (!bus.s_bvalid && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n >= LIMIT) begin errors++; $display("FAIL b_timeout: bvalid=%b required 1", bus.s_bvalid); end
    @(posedge clk); @(negedge clk);
    bus.s_bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_awvalid = 0; bus.s_awid = 0; bus.s_awaddr = 0; bus.s_awlen = 0; bus.s_awburst = 0;
    bus.s_wvalid = 0; bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wlast = 0; bus.s_bready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.s_awready !== 1'b1) begin errors++; $display("FAIL rst_awready: got %b want 1", bus.s_awready); end
    checks++; if (bus.s_wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", bus.s_wready); end
    checks++; if (bus.s_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bus.s_bvalid); end
    checks++; if ({bus.s_bresp, bus.s_bid} !== 5'b0) begin errors++; $display("FAIL rst_bresp_bid: got %b want 0", {bus.s_bresp, bus.s_bid}); end
    checks++; if (la !== 128'h0) begin errors++; $display("FAIL rst_la: got %h want 0", la); end
    checks++; if (gpio_oeb !== 28'hFFFFFFF) begin errors++; $display("FAIL rst_oeb: got %h want FFFFFFF", gpio_oeb); end
    checks++; if (pulse !== 4'b0) begin errors++; $display("FAIL rst_pulse: got %b want 0000", pulse); end
  endtask

  task automatic test_single_write();
    aw_send(3'd5, BASE, 8'd0, 2'b01);
    w_send(64'h1234_5678_0ABC_DEF0, 8'hFF, 1'b1);
    checks++; if (bus.s_bvalid !== 1'b1) begin errors++; $display("FAIL single_b_latency: bvalid %b want 1", bus.s_bvalid); end
    checks++; if (bus.s_bresp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b want 00", bus.s_bresp); end
    checks++; if (bus.s_bid !== 3'd5) begin errors++; $display("FAIL single_bid: got %0d want 5", bus.s_bid); end
    checks++; if (la !== {64'h0, 64'h1234_5678_0ABC_DEF0}) begin errors++; $display("FAIL single_regs: got %h", la); end
    checks++; if (pulse !== 4'b0011) begin errors++; $display("FAIL single_pulse: got %b want 0011", pulse); end
    checks++; if (gpio_out !== 28'hABCDEF0) begin errors++; $display("FAIL single_gpio: got %h want ABCDEF0", gpio_out); end
    b_ack();
    checks++; if (pulse !== 4'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0000", pulse); end
    checks++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1) begin errors++; $display("FAIL single_b_done: bvalid %b awready %b want 0 1", bus.s_bvalid, bus.s_awready); end
  endtask

  task automatic test_strobe_merge();
    aw_send(3'd1, BASE, 8'd0, 2'b01);
    w_send(64'h0000_0000_FFFF_FFFF, 8'h0F, 1'b1);
    b_ack();
    aw_send(3'd2, BASE, 8'd0, 2'b01);
    w_send(64'h0, 8'h05, 1'b1);
    checks++; if (la[63:0] !== 64'h1234_5678_FF00_FF00) begin errors++; $display("FAIL strb_merge: got %h want 12345678FF00FF00", la[63:0]); end
    checks++; if (pulse !== 4'b0001) begin errors++; $display("FAIL strb_pulse: got %b want 0001", pulse); end
    b_ack();
  endtask

  task automatic test_oe_reg();
    aw_send(3'd3, BASE + 32'd16, 8'd0, 2'b01);
    w_send(64'h0000_0000_FFFF_FFFF, 8'h0F, 1'b1);
    checks++; if (gpio_oeb !== 28'h0) begin errors++; $display("FAIL oe_oeb: got %h want 0", gpio_oeb); end
    checks++; if (bus.s_bresp !== 2'b00) begin errors++; $display("FAIL oe_bresp: got %b want 00", bus.s_bresp); end
    checks++; if (pulse !== 4'b0) begin errors++; $display("FAIL oe_pulse: got %b want 0000", pulse); end
    checks++; if (gpio_out !== 28'hF00FF00) begin errors++; $display("FAIL oe_gpio: got %h want F00FF00", gpio_out); end
    b_ack();
  endtask

  task automatic test_bursts();
    aw_send(3'd4, BASE, 8'd1, 2'b01);
    w_send(64'hA1A1A1A1_A0A0A0A0, 8'hFF, 1'b0);
    checks++; if (pulse !== 4'b0011) begin errors++; $display("FAIL incr_pulse0: got %b want 0011", pulse); end
    w_send(64'hA3A3A3A3_A2A2A2A2, 8'hFF, 1'b1);
    checks++; if (pulse !== 4'b1100) begin errors++; $display("FAIL incr_pulse1: got %b want 1100", pulse); end
    checks++; if (la !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) begin errors++; $display("FAIL incr_regs: got %h", la); end
    checks++; if (bus.s_bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b want 00", bus.s_bresp); end
    b_ack();
    aw_send(3'd6, BASE + 32'd8, 8'd1, 2'b00);
    w_send(64'hB1B1B1B1_B0B0B0B0, 8'hFF, 1'b0);
    checks++; if (la[127:64] !== 64'hB1B1B1B1_B0B0B0B0) begin errors++; $display("FAIL fixed_beat0: got %h", la[127:64]); end
    w_send(64'hC1C1C1C1_C0C0C0C0, 8'hFF, 1'b1);
    checks++; if (pulse !== 4'b1100) begin errors++; $display("FAIL fixed_pulse: got %b want 1100", pulse); end
    checks++; if (la !== 128'hC1C1C1C1_C0C0C0C0_A1A1A1A1_A0A0A0A0) begin errors++; $display("FAIL fixed_regs: got %h", la); end
    b_ack();
  endtask

  task automatic test_errors();
    localparam logic [127:0] KEEP = 128'hC1C1C1C1_C0C0C0C0_A1A1A1A1_A0A0A0A0;
    // Out-of-window address, response held while bready stays low.
    aw_send(3'd7, BASE + 32'd32, 8'd0, 2'b01);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    checks++; if (pulse !== 4'b0) begin errors++; $display("FAIL oor_pulse: got %b want 0000", pulse); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.s_bvalid !== 1'b1 || bus.s_bid !== 3'd7 || bus.s_bresp !== 2'b10) begin
        errors++; $display("FAIL oor_hold: bvalid %b bid %0d bresp %b want 1 7 10", bus.s_bvalid, bus.s_bid, bus.s_bresp);
      end
      @(negedge clk);
    end
    checks++; if (la !== KEEP || gpio_oeb !== 28'h0) begin errors++; $display("FAIL oor_regs: la %h oeb %h", la, gpio_oeb); end
    b_ack();
    // WRAP burst: both beats consumed, nothing written.
    aw_send(3'd2, BASE, 8'd1, 2'b10);
    w_send(64'h0, 8'hFF, 1'b0);
    w_send(64'h0, 8'hFF, 1'b1);
    checks++; if (bus.s_bresp !== 2'b10) begin errors++; $display("FAIL wrap_bresp: got %b want 10", bus.s_bresp); end
    checks++; if (la !== KEEP) begin errors++; $display("FAIL wrap_regs: got %h", la); end
    b_ack();
    // Early wlast on a two-beat burst.
    aw_send(3'd3, BASE, 8'd1, 2'b01);
    w_send(64'h0, 8'h00, 1'b1);
    checks++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b10) begin errors++; $display("FAIL early_last: bvalid %b bresp %b want 1 10", bus.s_bvalid, bus.s_bresp); end
    checks++; if (la !== KEEP) begin errors++; $display("FAIL early_last_regs: got %h", la); end
    b_ack();
    checks++; if (bus.s_awready !== 1'b1) begin errors++; $display("FAIL err_recover: awready %b want 1", bus.s_awready); end
  endtask

  task automatic test_aw_w_same_cycle();
    bus.s_awvalid = 1'b1; bus.s_awid = 3'd1; bus.s_awaddr = BASE; bus.s_awlen = 8'd0; bus.s_awburst = 2'b01;
    bus.s_wvalid = 1'b1; bus.s_wdata = 64'h5555_5555_6666_6666; bus.s_wstrb = 8'hFF; bus.s_wlast = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.s_awvalid = 1'b0;
    checks++; if (bus.s_wready !== 1'b1 || bus.s_bvalid !== 1'b0 || pulse !== 4'b0) begin
      errors++; $display("FAIL same_cycle_aw_only: wready %b bvalid %b pulse %b want 1 0 0000", bus.s_wready, bus.s_bvalid, pulse);
    end
    checks++; if (la[63:0] !== 64'hA1A1A1A1_A0A0A0A0) begin errors++; $display("FAIL same_cycle_early_write: got %h", la[63:0]); end
    @(posedge clk); @(negedge clk);
    bus.s_wvalid = 1'b0;
    checks++; if (bus.s_bvalid !== 1'b1 || la[63:0] !== 64'h5555_5555_6666_6666 || pulse !== 4'b0011) begin
      errors++; $display("FAIL same_cycle_w: bvalid %b la %h pulse %b", bus.s_bvalid, la[63:0], pulse);
    end
    b_ack();
  endtask

  task automatic test_reset_mid_burst();
    aw_send(3'd4, BASE, 8'd3, 2'b01);
    w_send(64'h7777_7777_8888_8888, 8'hFF, 1'b0);
    checks++; if (la[63:0] !== 64'h7777_7777_8888_8888) begin errors++; $display("FAIL mid_beat0: got %h", la[63:0]); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (la !== 128'h0 || gpio_oeb !== 28'hFFFFFFF) begin errors++; $display("FAIL mid_rst_regs: la %h oeb %h", la, gpio_oeb); end
    checks++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_wready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_hs: bvalid %b awready %b wready %b want 0 1 0", bus.s_bvalid, bus.s_awready, bus.s_wready);
    end
    aw_send(3'd2, BASE + 32'd8, 8'd0, 2'b01);
    w_send(64'h9999_9999_AAAA_AAAA, 8'hF0, 1'b1);
    checks++; if (la !== {32'h9999_9999, 96'h0} || pulse !== 4'b1000) begin errors++; $display("FAIL post_rst_write: la %h pulse %b", la, pulse); end
    checks++; if (bus.s_bresp !== 2'b00 || bus.s_bid !== 3'd2) begin errors++; $display("FAIL post_rst_b: bresp %b bid %0d want 00 2", bus.s_bresp, bus.s_bid); end
    b_ack();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_strobe_merge();
    test_oe_reg();
    test_bursts();
    test_errors();
    test_aw_w_same_cycle();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
